// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared start-by-reset divider core.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor bypasses the core with an error response.
module div_arbiter #(
  parameter int START_CYC   = 2,
  parameter int BLANK_CYC   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_n,
  input  logic [63:0] req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_n,
  input  logic [63:0] req1_d,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_q,
  output logic        resp_err,
  output logic        div_start,
  output logic [63:0] div_n,
  output logic [63:0] div_d,
  input  logic [63:0] div_q,
  input  logic        div_done
);

  // The core needs at least two reset cycles to restart cleanly.
  localparam int START_EFF = (START_CYC < 2) ? 2 : START_CYC;
  localparam logic [7:0] START_LAST = 8'(START_EFF - 1);
  localparam logic [7:0] BLANK_END  = 8'(BLANK_CYC);
  localparam logic [7:0] TO_LAST    = 8'(BLANK_CYC + TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] n_q, n_d;
  logic [63:0] d_q, d_d;
  logic [63:0] q_q, q_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        last_grant_q, last_grant_d;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        grant_vld;
  logic        grant_id;
  logic        accept;
  logic [63:0] acc_n;
  logic [63:0] acc_d;
  logic        d_zero;
  logic [7:0]  cnt_inc;

  assign req_valid = {req1_valid, req0_valid};

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = req_valid[1];
    if (&req_valid) begin
      grant_id = ~last_grant_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == IDLE) && !rst && grant_vld && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |req_ready;
  assign acc_n      = grant_id ? req1_n : req0_n;
  assign acc_d      = grant_id ? req1_d : req0_d;

`ifdef DIV_ZERO_TRAP_EN
  assign d_zero = (acc_d == 64'd0);
`else
  assign d_zero = 1'b0;
`endif

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    d_d          = d_q;
    q_d          = q_q;
    id_d         = id_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d          = acc_n;
          d_d          = acc_d;
          id_d         = grant_id;
          last_grant_d = grant_id;
          cnt_d        = 8'd0;
          if (d_zero) begin
            q_d     = '1;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d = cnt_inc;
        if (cnt_q >= START_LAST) begin
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // Early cycles ignore done: the core may still show the previous completion.
        if ((cnt_q >= BLANK_END) && div_done) begin
          q_d     = div_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= TO_LAST) begin
          q_d     = 64'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      n_q          <= 64'd0;
      d_q          <= 64'd0;
      q_q          <= 64'd0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      d_q          <= d_d;
      q_q          <= q_d;
      id_q         <= id_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign div_start  = (state_q == START);
  assign div_n      = n_q;
  assign div_d      = d_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_q     = q_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: timestamp-based reference model checked every cycle,
// a behavioural divider core, and directed scenarios with literal expectations.
module tb_div_arbiter;

  localparam int S  = 2;
  localparam int B  = 1;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_n, req0_d, req1_n, req1_d;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [63:0] resp_q;
  logic        div_start, div_done;
  logic [63:0] div_n, div_d, div_q;

  div_arbiter #(.START_CYC(S), .BLANK_CYC(B), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_err(resp_err),
    .div_start(div_start), .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // 32.32 fixed-point quotient; a zero divisor yields all ones
  function automatic logic [63:0] fx_div(input logic [63:0] n, input logic [63:0] d);
    logic [127:0] num, quo;
    if (d == 64'd0) return '1;
    num = {32'd0, n, 32'd0};
    quo = num / {64'd0, d};
    return quo[63:0];
  endfunction

  // Behavioural core: done clears while started, rises core_lat cycles after start falls
  int core_lat   = 20;
  bit core_stale = 1'b0;
  int core_cnt   = 1000;
  always @(posedge clk) begin
    #1;
    if (div_start) begin
      core_cnt = 0;
      div_done = core_stale;
      div_q    = 64'd0;
    end else begin
      if (core_cnt < 1000) core_cnt++;
      if (core_stale) div_done = (core_cnt == 1) || (core_cnt >= 12);
      else            div_done = (core_lat > 0) && (core_cnt >= core_lat);
      div_q = fx_div(div_n, div_d);
    end
  end

  // Reference model state
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0, m_last = 1'b1, m_known, m_trap, m_id;
  int          m_acc, m_resp_cyc;
  logic [63:0] m_n, m_d, m_q;
  bit          m_err;
  int          acc_cnt = 0;
  bit          g_ok, g, exp_start, exp_valid;

  // Observations of the DUT for the directed checks
  int          grant_log[$];
  int          resp_id_log[$];
  logic [63:0] last_q;
  bit          last_err, last_id, prev_valid;
  int          dut_acc, dut_first, hs_cyc, start_cnt, valid_cycles;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      prev_valid = 1'b0;
    end else if (chk_en) begin
      g_ok = 1'b0;
      g    = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin g_ok = 1'b1; g = !m_last; end
        else if (req0_valid)          begin g_ok = 1'b1; g = 1'b0; end
        else if (req1_valid)          begin g_ok = 1'b1; g = 1'b1; end
      end
      exp_start = m_busy && !m_trap && (cyc >= m_acc + 1) && (cyc <= m_acc + S);
      exp_valid = m_busy && m_known && (cyc >= m_resp_cyc);

      chk("req0_ready", req0_ready, g_ok && !g);
      chk("req1_ready", req1_ready, g_ok && g);
      chk("div_start", div_start, exp_start);
      chk("resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_q", resp_q, m_q);
        chk("resp_err", resp_err, m_err);
      end
      if (m_busy) begin
        chk("div_n", div_n, m_n);
        chk("div_d", div_d, m_d);
      end

      if (req0_ready && req0_valid) begin grant_log.push_back(0); dut_acc = cyc; start_cnt = 0; end
      if (req1_ready && req1_valid) begin grant_log.push_back(1); dut_acc = cyc; start_cnt = 0; end
      if (div_start) start_cnt++;
      if (resp_valid) valid_cycles++;
      if (resp_valid && !prev_valid) dut_first = cyc;
      prev_valid = resp_valid;
      if (resp_valid && resp_ready) begin
        resp_id_log.push_back(int'(resp_id));
        last_q   = resp_q;
        last_err = resp_err;
        last_id  = resp_id;
        hs_cyc   = cyc;
      end

      if (m_busy) begin
        if (exp_valid && resp_ready) begin
          m_busy = 1'b0;
        end else if (!m_known) begin
          if ((cyc >= m_acc + S + B + 1) && div_done) begin
            m_known = 1'b1; m_resp_cyc = cyc + 1; m_q = div_q; m_err = 1'b0;
          end else if (cyc >= m_acc + S + B + TO) begin
            m_known = 1'b1; m_resp_cyc = cyc + 1; m_q = 64'd0; m_err = 1'b1;
          end
        end
      end else if (g_ok) begin
        m_busy  = 1'b1;
        m_acc   = cyc;
        m_id    = g;
        m_last  = g;
        m_n     = g ? req1_n : req0_n;
        m_d     = g ? req1_d : req0_d;
        m_known = 1'b0;
        m_trap  = 1'b0;
        acc_cnt++;
`ifdef DIV_ZERO_TRAP_EN
        if (m_d == 64'd0) begin
          m_trap = 1'b1; m_known = 1'b1; m_resp_cyc = cyc + 1; m_q = '1; m_err = 1'b1;
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit id, input logic [63:0] n, input logic [63:0] d);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_n = n; req1_d = d; end
    else    begin req0_valid = 1'b1; req0_n = n; req0_d = d; end
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (acc_cnt != a0) ok = 1'b1;
    end
    if (!ok) bound_fail("accept");
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (!m_busy) ok = 1'b1;
    end
    if (!ok) bound_fail("idle");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_div_start"}, div_start, 1'b0);
    chk({tag, "_resp_id"}, resp_id, 1'b0);
    chk({tag, "_resp_q"}, resp_q, 64'd0);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_div_n"}, div_n, 64'd0);
    chk({tag, "_div_d"}, div_d, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, v0;
    bit ok;
    logic [63:0] q0;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = '0; req0_d = '0; req1_n = '0; req1_d = '0;
    resp_ready = 1'b1;
    div_done = 1'b0; div_q = '0;
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset_values("reset");

    // Single operation: 100 / 5 in 32.32
    core_lat = 20;
    do_op(1'b0, 64'h0000_0064_0000_0000, 64'h0000_0005_0000_0000);
    wait_idle(200);
    chk("t1_latency", dut_first - dut_acc, 23);
    chk("t1_model_latency", m_resp_cyc - m_acc, 23);
    chk("t1_start_cycles", start_cnt, 2);
    chk("t1_q", last_q, 64'h0000_0014_0000_0000);
    chk("t1_id", last_id, 1'b0);
    chk("t1_err", last_err, 1'b0);

    // Contention after a fresh reset: ties alternate starting with requester 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    grant_log.delete();
    resp_id_log.delete();
    core_lat = 3;
    req0_n = 64'h0000_0008_0000_0000; req0_d = 64'h0000_0002_0000_0000;
    req1_n = 64'h0000_0009_0000_0000; req1_d = 64'h0000_0003_0000_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick(1);
      if (resp_id_log.size() >= 4) ok = 1'b1;
    end
    if (!ok) bound_fail("contention");
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
      chk("t2_resp_order", (i < resp_id_log.size()) ? resp_id_log[i] : -1, i % 2);
    end
    tick(2);

    // Stale done through START and first WAIT cycle must be ignored
    core_stale = 1'b1;
    do_op(1'b1, 64'h0000_0010_0000_0000, 64'h0000_0004_0000_0000);
    wait_idle(200);
    core_stale = 1'b0;
    chk("t3_latency", dut_first - dut_acc, 15);
    chk("t3_q", last_q, 64'h0000_0004_0000_0000);
    chk("t3_err", last_err, 1'b0);
    chk("t3_id", last_id, 1'b1);

    // Timeout: core never completes
    core_lat = 0;
    do_op(1'b0, 64'h0000_0001_0000_0000, 64'h0000_0007_0000_0000);
    wait_idle(300);
    chk("t4_latency", dut_first - dut_acc, 68);
    chk("t4_model_latency", m_resp_cyc - m_acc, 68);
    chk("t4_err", last_err, 1'b1);
    chk("t4_q", last_q, 64'd0);

    // Backpressure, then reset during WAIT of the follow-on operation
    core_lat = 4;
    resp_ready = 1'b0;
    do_op(1'b0, 64'h0000_0009_0000_0000, 64'h0000_0003_0000_0000);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (resp_valid) ok = 1'b1;
    end
    if (!ok) bound_fail("bp_resp");
    req1_valid = 1'b1; req1_n = 64'h0000_0020_0000_0000; req1_d = 64'h0000_0002_0000_0000;
    g0 = grant_log.size();
    q0 = 64'h0000_0003_0000_0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_q", resp_q, q0);
      chk("bp_id", resp_id, 1'b0);
      tick(1);
    end
    chk("bp_no_grant", grant_log.size(), g0);
    core_lat = 30;
    v0 = acc_cnt;
    resp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (acc_cnt != v0) ok = 1'b1;
    end
    if (!ok) bound_fail("bp_next_accept");
    req1_valid = 1'b0;
    chk("bp_accept_gap", dut_acc - hs_cyc, 1);
    chk("bp_next_id", (grant_log.size() > 0) ? grant_log[grant_log.size() - 1] : -1, 1);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_values("midrst");
    v0 = valid_cycles;
    tick(50);
    chk("midrst_no_stale_resp", valid_cycles - v0, 0);

    // Zero divisor
    core_lat = 5;
    do_op(1'b1, 64'h0000_0001_0000_0000, 64'd0);
    wait_idle(200);
    chk("t6_q", last_q, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef DIV_ZERO_TRAP_EN
    chk("t6_latency", dut_first - dut_acc, 1);
    chk("t6_start_cycles", start_cnt, 0);
    chk("t6_err", last_err, 1'b1);
`else
    chk("t6_latency", dut_first - dut_acc, 8);
    chk("t6_start_cycles", start_cnt, 2);
    chk("t6_err", last_err, 1'b0);
`endif
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

- Shares one 64-bit Goldschmidt divider (`gs_div`-style core: start-by-reset, `done` level output) between two requesters.
- Accepts one division at a time via valid/ready, using round-robin arbitration.
- Sequences the core's start pulse and completion wait, with done-blanking and timeout.
- Returns the quotient on a single response channel tagged with the requester ID.

## Interface
Parameters:
- `START_CYC`, default 2: cycles `div_start` is held high per operation (minimum 2).
- `BLANK_CYC`, default 1: cycles after `div_start` falls during which `div_done` is ignored.
- `TIMEOUT_CYC`, default 64: maximum cycles waiting for `div_done` before an error response is issued.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_n`  in  64  requester 0 dividend.
- `req0_d`  in  64  requester 0 divisor.
- `req1_valid`, `req1_ready`, `req1_n`, `req1_d`: same as the requester 0 ports, for requester 1.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_id`  out  1  requester that issued the operation.
- `resp_q`  out  64  quotient, in the core's fixed-point format (passed through unchanged).
- `resp_err`  out  1  timeout, or trapped divide-by-zero.
- `div_start`  out  1  drives the core's `rst` input.
- `div_n`  out  64  core dividend.
- `div_d`  out  64  core divisor.
- `div_q`  in  64  core quotient.
- `div_done`  in  1  core completion.

## Operation
States: IDLE, START, WAIT, RESP.

- **IDLE:** the arbiter picks one requester.
  - If only one `reqX_valid` is high, that requester is granted.
  - If both are high, the requester not named by `last_grant` is granted.
  - `reqX_ready` is high combinationally, for the granted requester only, and only in IDLE.
  - On acceptance: latch n, d and id into operand registers, update `last_grant`, go to START.
- **START:** `div_start` = 1 for exactly `START_CYC` cycles, then go to WAIT.
  - The counter is cleared on entry.
- **WAIT:** `div_start` = 0.
  - The first `BLANK_CYC` cycles ignore `div_done`.
  - After blanking, the first cycle with `div_done` = 1 captures `div_q` into `resp_q`, sets `resp_err` = 0, and goes to RESP.
  - If the wait counter reaches `TIMEOUT_CYC` with no done: `resp_q` = 0, `resp_err` = 1, go to RESP.
- **RESP:** `resp_valid` = 1, with `resp_q`, `resp_id` and `resp_err` held stable.
  - When `resp_ready` = 1, go to IDLE.
  - No new request is accepted in the same cycle.
- `div_n` and `div_d` always come from the operand registers, and are stable from START through RESP.
- A request deasserted before acceptance is simply not granted. There is no obligation on the requester to hold valid.
- Counters are 8 bits; they saturate at 255, and they never wrap.
- The block holds at most one operation in flight. There is no queue.

## Timing
Reset values: `reqX_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_q` = 0, `resp_err` = 0, `div_start` = 0, operand registers = 0, `last_grant` = 1 (so requester 0 wins the first tie), state = IDLE.

Cycle-level behaviour:
- Acceptance happens at cycle T.
- `div_start` is high during T+1 … T+`START_CYC`.
- Blanking covers the next `BLANK_CYC` cycles.
- A done seen at cycle W gives `resp_valid` high from W+1.
- Minimum latency from acceptance to `resp_valid` = `START_CYC` + `BLANK_CYC` + 2.
- When `resp_ready` is high at cycle R, `resp_valid` is low at R+1, and a new acceptance is possible at R+1.

Boundary conditions:
- `rst` mid-operation: the next cycle is IDLE with all outputs at their reset values.
  - The in-flight result is discarded, and no response is issued for it.
- Both requesters valid in back-to-back operations: grants alternate 0, 1, 0, 1.
- `div_done` high during blanking (stale completion from the core's idle state) must not complete the operation.
- `resp_ready` high while `resp_valid` is low has no effect.

## Configuration
- Macro `DIV_ZERO_TRAP_EN`.
- Defined: an accepted operation whose d == 0 skips START and WAIT.
  - The block goes directly to RESP the next cycle with `resp_q` = 64'hFFFF_FFFF_FFFF_FFFF and `resp_err` = 1.
  - `div_start` never pulses for that operation.
- Undefined: a d == 0 operation is issued to the core like any other. Its result or timeout is reported as-is.

## Test plan
- Single operation: requester 0, n = 64'h0000_0064_0000_0000, d = 64'h0000_0005_0000_0000; core model completes in 20 cycles with q = 64'h0000_0014_0000_0000 → `resp_valid` with `resp_id` = 0, `resp_q` = 64'h0000_0014_0000_0000, `resp_err` = 0.
  - `div_start` must be high for exactly 2 cycles.
- Contention: both requesters valid continuously for 4 operations → grant order 0, 1, 0, 1; `resp_id` follows the same order; `reqX_ready` is never high for both requesters in one cycle.
- Stale done: core model holds `div_done` = 1 through START and the first WAIT cycle, then 0, then 1 after 10 cycles → completion happens only at the later done.
- Timeout: core never raises done → `resp_valid` with `resp_err` = 1 and `resp_q` = 0, exactly 64 WAIT cycles after blanking ends.
- Backpressure and reset: `resp_ready` held low for 5 cycles → response stays stable and no grant occurs; a later `rst` during WAIT → IDLE next cycle, `resp_valid` = 0, and no stale response afterwards.
- With `DIV_ZERO_TRAP_EN` defined, d = 0 → response one cycle after acceptance, `resp_err` = 1, `resp_q` all ones, and `div_start` never high.
